// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect controller for a 5-stage RV32 pipeline.
// Stall, flush and redirect outputs are combinational, so they act on the next edge.
// The FSM tracks a stale in-flight fetch after a redirect (SQUASH).
// Inside each pipeline register, flush dominates stall.
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_mem_r,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_branch_taken,
  input  logic             if_fetch_valid,
  input  logic             if_fetch_pending,
  input  logic             mem_dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             mem_wb_flush,
  output logic             squash_active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             dmem_timeout
);

  typedef enum logic {ST_RUN, ST_SQUASH} state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t             state_q, state_d;
  logic               squash_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [15:0]        to_cnt_q;
  logic               timeout_q;

  logic dwait, load_use;
  logic if_id_stall_raw, id_ex_stall_raw, ex_mem_stall_raw, mem_wb_stall_raw;

  assign dwait    = mem_dmem_req & ~dmem_ready;
  assign load_use = ex_mem_r & (ex_wr_addr != 5'd0) &
                    ((id_rs1_used & (id_rs1_addr == ex_wr_addr)) |
                     (id_rs2_used & (id_rs2_addr == ex_wr_addr)));

  // Hazard resolution and next-state selection; all outputs forced low during reset.
  always_comb begin
    state_d          = state_q;
    pc_stall         = 1'b0;
    pc_redirect      = 1'b0;
    if_id_stall_raw  = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_stall_raw  = 1'b0;
    id_ex_flush      = 1'b0;
    ex_mem_stall_raw = 1'b0;
    ex_mem_flush     = 1'b0;
    mem_wb_stall_raw = 1'b0;
    mem_wb_flush     = 1'b0;
    if (!rst) begin
      if (state_q == ST_RUN) begin
        if (dwait) begin
          pc_stall         = 1'b1;
          if_id_stall_raw  = 1'b1;
          id_ex_stall_raw  = 1'b1;
          ex_mem_stall_raw = 1'b1;
          mem_wb_stall_raw = 1'b1;
        end else if (ex_branch_taken) begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          // A fetch still in flight would return a wrong-path word.
          if (if_fetch_pending && !if_fetch_valid) state_d = ST_SQUASH;
        end else if (load_use) begin
          pc_stall        = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_flush     = 1'b1;
        end else if (!if_fetch_valid) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
        end
      end else begin
        // Keep the stale fetch out of ID until it returns.
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        if (dwait) begin
          if_id_stall_raw  = 1'b1;
          id_ex_stall_raw  = 1'b1;
          ex_mem_stall_raw = 1'b1;
          mem_wb_stall_raw = 1'b1;
        end
        if (ex_branch_taken) begin
          pc_redirect = 1'b1;
          id_ex_flush = 1'b1;
        end else if (if_fetch_valid) begin
          state_d = ST_RUN;
        end
      end
    end
    if_id_stall  = if_id_stall_raw  & ~if_id_flush;
    id_ex_stall  = id_ex_stall_raw  & ~id_ex_flush;
    ex_mem_stall = ex_mem_stall_raw & ~ex_mem_flush;
    mem_wb_stall = mem_wb_stall_raw & ~mem_wb_flush;
  end

  // FSM state register with registered squash indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= (state_d == ST_SQUASH);
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Consecutive dmem-wait counter (saturates at the limit) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else if (dwait) begin
      if (to_cnt_q != TO_LIM) to_cnt_q <= to_cnt_q + 16'd1;
      if (to_cnt_q >= TO_LIM - 16'd1) timeout_q <= 1'b1;
    end else begin
      to_cnt_q <= 16'd0;
    end
  end

  assign squash_active = squash_q;
  assign stall_cycles  = stall_cnt_q;
  assign dmem_timeout  = timeout_q;

endmodule
